// File: rtl/fb_pkg.sv
// Shared sizes and entry layout for the fetch buffer.
package fb_pkg;

  localparam int FB_DEPTH = 16;
  localparam int FB_PTR_W = 4;

  localparam logic [1:0] EXC_NONE = 2'b00;

  typedef struct packed {
    logic [29:0] pc;
    logic [31:0] inst;
    logic [1:0]  except;
    logic [31:0] target;
  } fb_entry_t;

endpackage

// File: rtl/fb_compact.sv
// Turns a 4-slot fetch packet into a dense list of buffer entries plus a write count.
module fb_compact
  import fb_pkg::*;
(
  input  logic [3:0]             mask,
  input  logic [1:0]             fetch_except,
  input  logic [27:0]            pc_base,
  input  logic [127:0]           inst,
  input  logic [31:0]            fetch_target,
  output fb_entry_t [3:0]        entry,
  output logic [2:0]             wr_cnt,
  output logic [3:0][29:0]       slot_pc,
  output logic [3:0][31:0]       slot_target
);

  logic      [3:0] is_last;
  logic      [3:0] is_first;
  fb_entry_t [3:0] slot_entry;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_slot
      localparam logic [3:0] ABOVE = 4'(32'hF << (gi + 1));
      localparam logic [3:0] BELOW = 4'((32'd1 << gi) - 32'd1);

      assign slot_pc[gi]  = {pc_base, 2'(gi)};
      assign is_last[gi]  = mask[gi] && ((mask & ABOVE) == 4'd0);
      assign is_first[gi] = mask[gi] && ((mask & BELOW) == 4'd0);
      // The last valid slot inherits the branch prediction; earlier slots fall through.
      assign slot_target[gi] = is_last[gi] ? fetch_target
                                           : ({slot_pc[gi], 2'b00} + 32'd4);

      assign slot_entry[gi] = '{pc:     slot_pc[gi],
                                inst:   inst[32*gi +: 32],
                                except: EXC_NONE,
                                target: slot_target[gi]};
    end
  endgenerate

  always_comb begin
    entry  = '0;
    wr_cnt = 3'd0;
    if (fetch_except != EXC_NONE) begin
      // A faulting packet keeps only its first instruction to carry the exception.
      for (int i = 0; i < 4; i++) begin
        if (is_first[i]) begin
          entry[0]        = slot_entry[i];
          entry[0].except = fetch_except;
          entry[0].target = fetch_target;
          wr_cnt          = 3'd1;
        end
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (mask[i]) begin
          entry[wr_cnt[1:0]] = slot_entry[i];
          wr_cnt             = wr_cnt + 3'd1;
        end
      end
    end
  end

endmodule

// File: rtl/fetch_buffer.sv
// Circular instruction FIFO between fetch and the two decode lanes.
module fetch_buffer
  import fb_pkg::*;
#(
  parameter int DEPTH = FB_DEPTH,
  parameter int PTR_W = FB_PTR_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_stage3,
  input  logic         hold_stage3,
  input  logic         fetch_vld,
  output logic         fetch_ready,
  input  logic [31:0]  fetch_pc,
  input  logic [3:0]   fetch_mask,
  input  logic [127:0] fetch_inst,
  input  logic [1:0]   fetch_except,
  input  logic [31:0]  fetch_target,
  output logic         instruction_vld_0,
  output logic         instruction_vld_1,
  output logic [31:0]  instruction_0,
  output logic [31:0]  instruction_1,
  output logic [31:0]  PC_stage2_0,
  output logic [31:0]  PC_stage2_1,
  output logic [1:0]   except_stage2_0,
  output logic [1:0]   except_stage2_1,
  output logic [31:0]  instruction_target_stage2_0,
  output logic [31:0]  instruction_target_stage2_1
);

  localparam logic [PTR_W:0] DEPTH_C     = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0] READY_LIMIT = (PTR_W + 1)'(DEPTH - 4);

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  fb_entry_t        mem_q [DEPTH];

  fb_entry_t [3:0]  comp_entry;
  logic [2:0]       comp_cnt;
  logic [3:0][29:0] slot_pc;
  logic [3:0][31:0] slot_target;

  logic             write_en;
  logic [2:0]       wr_num;
  logic [1:0]       pop_num;
  fb_entry_t        lane_0, lane_1;
  logic             unused_pc_lo;

  assign unused_pc_lo = ^fetch_pc[3:0];

  fb_compact u_compact (
    .mask         (fetch_mask),
    .fetch_except (fetch_except),
    .pc_base      (fetch_pc[31:4]),
    .inst         (fetch_inst),
    .fetch_target (fetch_target),
    .entry        (comp_entry),
    .wr_cnt       (comp_cnt),
    .slot_pc      (slot_pc),
    .slot_target  (slot_target)
  );

  // Readiness looks only at registered occupancy so fetch never depends on decode timing.
  assign fetch_ready = (count_q <= READY_LIMIT);
  assign write_en    = fetch_vld && fetch_ready && !flush_stage3;
  assign wr_num      = write_en ? comp_cnt : 3'd0;

  assign instruction_vld_0 = (count_q >= (PTR_W + 1)'(1)) && !flush_stage3;
  assign instruction_vld_1 = (count_q >= (PTR_W + 1)'(2)) && !flush_stage3;
  assign pop_num = hold_stage3 ? 2'd0
                 : (2'(instruction_vld_0) + 2'(instruction_vld_1));

  always_comb begin
    head_d  = head_q + PTR_W'(pop_num);
    tail_d  = tail_q + PTR_W'(wr_num);
    count_d = count_q + (PTR_W + 1)'(wr_num) - (PTR_W + 1)'(pop_num);
    if (flush_stage3) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int j = 0; j < 4; j++) begin
      if (write_en && (3'(j) < comp_cnt)) begin
        mem_q[tail_q + PTR_W'(j)] <= comp_entry[j];
      end
    end
  end

  assign lane_0 = mem_q[head_q];
  assign lane_1 = mem_q[head_q + PTR_W'(1)];

  assign instruction_0               = lane_0.inst;
  assign instruction_1               = lane_1.inst;
  assign PC_stage2_0                 = {lane_0.pc, 2'b00};
  assign PC_stage2_1                 = {lane_1.pc, 2'b00};
  assign except_stage2_0             = lane_0.except;
  assign except_stage2_1             = lane_1.except;
  assign instruction_target_stage2_0 = lane_0.target;
  assign instruction_target_stage2_1 = lane_1.target;

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (count_q <= DEPTH_C);
      assert (!(wr_num != 3'd0 && !fetch_ready));
      assert (!(write_en && fetch_mask[0] && fetch_except == EXC_NONE &&
                (comp_entry[0].pc != slot_pc[0] || comp_entry[0].target != slot_target[0])));
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed plus random stimulus against a queue-based model of the fetch buffer.
module tb_fetch_buffer;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush_stage3, hold_stage3, fetch_vld, fetch_ready;
  logic [31:0]  fetch_pc, fetch_target;
  logic [3:0]   fetch_mask;
  logic [127:0] fetch_inst;
  logic [1:0]   fetch_except;
  logic         instruction_vld_0, instruction_vld_1;
  logic [31:0]  instruction_0, instruction_1, PC_stage2_0, PC_stage2_1;
  logic [1:0]   except_stage2_0, except_stage2_1;
  logic [31:0]  instruction_target_stage2_0, instruction_target_stage2_1;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [1:0]  exc;
    logic [31:0] tgt;
  } ref_t;

  ref_t model_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  always #5 clk = ~clk;

  fetch_buffer dut (
    .clk                         (clk),
    .rst                         (rst),
    .flush_stage3                (flush_stage3),
    .hold_stage3                 (hold_stage3),
    .fetch_vld                   (fetch_vld),
    .fetch_ready                 (fetch_ready),
    .fetch_pc                    (fetch_pc),
    .fetch_mask                  (fetch_mask),
    .fetch_inst                  (fetch_inst),
    .fetch_except                (fetch_except),
    .fetch_target                (fetch_target),
    .instruction_vld_0           (instruction_vld_0),
    .instruction_vld_1           (instruction_vld_1),
    .instruction_0               (instruction_0),
    .instruction_1               (instruction_1),
    .PC_stage2_0                 (PC_stage2_0),
    .PC_stage2_1                 (PC_stage2_1),
    .except_stage2_0             (except_stage2_0),
    .except_stage2_1             (except_stage2_1),
    .instruction_target_stage2_0 (instruction_target_stage2_0),
    .instruction_target_stage2_1 (instruction_target_stage2_1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s (cycle %0d): observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #3;
    rst = 1'b0;
    model_q.delete();
    @(posedge clk);
    #1;
  endtask

  // One clock of stimulus: drive, check combinational outputs, advance model and DUT.
  task automatic cycle(input logic vld, input logic [31:0] pc, input logic [3:0] mask,
                       input logic [1:0] exc, input logic [31:0] tgt,
                       input logic hold, input logic flush);
    int          sz;
    int          lo;
    int          hi;
    logic        rdy;
    logic [31:0] base;
    ref_t        e;
    fetch_vld    = vld;
    fetch_pc     = pc;
    fetch_mask   = mask;
    fetch_except = exc;
    fetch_target = tgt;
    hold_stage3  = hold;
    flush_stage3 = flush;
    for (int i = 0; i < 4; i++) fetch_inst[32*i +: 32] = $urandom;
    #1;
    sz  = model_q.size();
    rdy = (sz <= 12);
    check("fetch_ready", 32'(fetch_ready), 32'(rdy));
    check("vld_0", 32'(instruction_vld_0), 32'(sz >= 1 && !flush));
    check("vld_1", 32'(instruction_vld_1), 32'(sz >= 2 && !flush));
    if (sz >= 1 && !flush) begin
      check("inst_0",   instruction_0,                   model_q[0].inst);
      check("pc_0",     PC_stage2_0,                     model_q[0].pc);
      check("except_0", 32'(except_stage2_0),            32'(model_q[0].exc));
      check("target_0", instruction_target_stage2_0,     model_q[0].tgt);
    end
    if (sz >= 2 && !flush) begin
      check("inst_1",   instruction_1,                   model_q[1].inst);
      check("pc_1",     PC_stage2_1,                     model_q[1].pc);
      check("except_1", 32'(except_stage2_1),            32'(model_q[1].exc));
      check("target_1", instruction_target_stage2_1,     model_q[1].tgt);
    end
    $display("cyc %0d: vld=%0b pc=%h mask=%b exc=%0d hold=%0b flush=%0b occ=%0d",
             cyc, vld, pc, mask, exc, hold, flush, sz);

    if (flush) begin
      model_q.delete();
    end else begin
      if (!hold) repeat ((sz >= 2) ? 2 : sz) void'(model_q.pop_front());
      if (vld && rdy && mask != 4'd0) begin
        base = {pc[31:4], 4'h0};
        lo = 4;
        hi = -1;
        for (int i = 0; i < 4; i++) if (mask[i]) begin
          if (lo == 4) lo = i;
          hi = i;
        end
        if (exc != 2'b00) begin
          e.pc   = base + 32'(4 * lo);
          e.inst = fetch_inst[32*lo +: 32];
          e.exc  = exc;
          e.tgt  = tgt;
          model_q.push_back(e);
        end else begin
          for (int i = lo; i <= hi; i++) begin
            e.pc   = base + 32'(4 * i);
            e.inst = fetch_inst[32*i +: 32];
            e.exc  = 2'b00;
            e.tgt  = (i == hi) ? tgt : e.pc + 32'd4;
            model_q.push_back(e);
          end
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input logic hold);
    cycle(1'b0, 32'h0, 4'h0, 2'b00, 32'h0, hold, 1'b0);
  endtask

  initial begin
    int          lo;
    int          hi;
    logic [3:0]  mask;
    logic [1:0]  exc;
    rst = 1'b0;
    flush_stage3 = 1'b0;
    hold_stage3  = 1'b0;
    fetch_vld    = 1'b0;
    fetch_pc     = '0;
    fetch_mask   = '0;
    fetch_inst   = '0;
    fetch_except = '0;
    fetch_target = '0;
    #2;
    do_reset();

    // Reset then idle
    idle(1'b0);
    idle(1'b0);

    // Full packet, drained two per cycle
    cycle(1'b1, 32'h1C000000, 4'b1111, 2'b00, 32'h1C000100, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b0);
    idle(1'b0);

    // Partial packet, then exception packet
    cycle(1'b1, 32'h1C000010, 4'b1100, 2'b00, 32'h1C000020, 1'b0, 1'b0);
    cycle(1'b1, 32'h1C000020, 4'b1111, 2'b01, 32'h1C000444, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b0);
    idle(1'b0);

    // Fill under hold, fifth packet refused, then release
    for (int k = 0; k < 5; k++)
      cycle(1'b1, 32'h2000_0000 + 32'(16 * k), 4'b1111, 2'b00, 32'h3000_0000 + 32'(k), 1'b1, 1'b0);
    idle(1'b1);
    for (int k = 0; k < 9; k++) idle(1'b0);

    // Wrap-around: tail reaches 14, then a 4-slot packet straddles the boundary
    do_reset();
    for (int k = 0; k < 3; k++)
      cycle(1'b1, 32'h4000_0000 + 32'(16 * k), 4'b1111, 2'b00, 32'h4000_0000 + 32'(16 * k + 16), 1'b0, 1'b0);
    cycle(1'b1, 32'h4000_0030, 4'b0011, 2'b00, 32'h4000_0040, 1'b0, 1'b0);
    cycle(1'b1, 32'h4000_0040, 4'b1111, 2'b00, 32'h5000_0000, 1'b1, 1'b0);
    for (int k = 0; k < 6; k++) idle(1'b0);

    // Flush with simultaneous write and hold at occupancy 6
    cycle(1'b1, 32'h6000_0000, 4'b1111, 2'b00, 32'h6000_0010, 1'b1, 1'b0);
    cycle(1'b1, 32'h6000_0010, 4'b0011, 2'b00, 32'h6000_0018, 1'b1, 1'b0);
    cycle(1'b1, 32'h6000_0020, 4'b1111, 2'b00, 32'h6000_0030, 1'b1, 1'b1);
    idle(1'b0);
    idle(1'b0);

    // Zero mask with fetch_vld writes nothing
    cycle(1'b1, 32'h7000_0000, 4'b0000, 2'b00, 32'h7000_0010, 1'b0, 1'b0);
    idle(1'b0);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      lo   = $urandom_range(0, 3);
      hi   = $urandom_range(lo, 3);
      mask = 4'(((32'd1 << (hi + 1)) - 32'd1) & ~((32'd1 << lo) - 32'd1));
      if ($urandom_range(0, 9) == 0) mask = 4'd0;
      exc  = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      cycle(1'($urandom_range(0, 3) != 0), $urandom, mask, exc, $urandom,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0));
    end
    for (int k = 0; k < 10; k++) idle(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
